// File: rtl/uart_core.sv
// 8N1 UART with 16x oversampling, full duplex, shared free-running tick divisor.
// State table:
//   rx IDLE  | line idle, waiting for a falling edge
//   rx START | counting to the start-bit midpoint, rejecting glitches
//   rx DATA  | sampling 8 data bits, LSB first, one per bit time
//   rx STOP  | sampling the stop bit, then flag the byte or a framing error
//   tx IDLE  | line high, ready to accept tx_wr
//   tx WAIT  | byte latched, waiting for the next tick to start the frame
//   tx SEND  | shifting out start, data and stop bits, 16 ticks each
module uart_core #(
  parameter int freq_hz = 50000000,
  parameter int baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int DIV_RAW = freq_hz / (16 * baud);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;

  logic [1:0]    rxd_sync;
  logic          rxd_s;
  rx_state_t     rx_state, rx_next;
  logic [3:0]    rx_tcnt;
  logic [2:0]    rx_bcnt;
  logic [7:0]    rx_shift;
  logic          rx_bit_stb, rx_stop_stb;

  tx_state_t     tx_state, tx_next;
  logic [3:0]    tx_tcnt;
  logic [3:0]    tx_bcnt;
  logic [9:0]    tx_shift;

  assign tick  = (div_cnt == '0);
  assign rxd_s = rxd_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      rxd_sync <= 2'b11;
    end else begin
      div_cnt  <= tick ? DW'(DIV - 1) : div_cnt - 1'b1;
      rxd_sync <= {rxd_sync[0], uart_rxd};
    end
  end

  // RX: the tick counter preloads 7 in IDLE so START ends at the bit midpoint
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rxd_s) rx_next = RX_START;
      RX_START: if (tick && rx_tcnt == 4'd0) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && rx_tcnt == 4'd0 && rx_bcnt == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick && rx_tcnt == 4'd0) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  assign rx_bit_stb  = (rx_state == RX_DATA) && tick && (rx_tcnt == 4'd0);
  assign rx_stop_stb = (rx_state == RX_STOP) && tick && (rx_tcnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= 4'd7;
      rx_bcnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_avail <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        rx_tcnt <= 4'd7;
        rx_bcnt <= 3'd0;
      end else if (tick) begin
        rx_tcnt <= (rx_tcnt == 4'd0) ? 4'd15 : rx_tcnt - 4'd1;
      end
      if (rx_bit_stb) begin
        rx_shift <= {rxd_s, rx_shift[7:1]};
        rx_bcnt  <= rx_bcnt + 3'd1;
      end
      // completion takes priority over a coincident acknowledge
      if (rx_stop_stb && rxd_s) begin
        rx_data  <= rx_shift;
        rx_avail <= 1'b1;
      end else if (rx_ack) begin
        rx_avail <= 1'b0;
      end
      if (rx_stop_stb && !rxd_s) rx_error <= 1'b1;
      else if (rx_ack)           rx_error <= 1'b0;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_wr) tx_next = TX_WAIT;
      TX_WAIT: if (tick) tx_next = TX_SEND;
      TX_SEND: if (tick && tx_tcnt == 4'd0 && tx_bcnt == 4'd9) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= 4'd15;
      tx_bcnt  <= 4'd0;
      tx_shift <= 10'h3FF;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE && tx_wr) begin
        tx_shift <= {1'b1, tx_data, 1'b0};
        tx_tcnt  <= 4'd15;
        tx_bcnt  <= 4'd0;
      end else if (tx_state == TX_SEND && tick) begin
        if (tx_tcnt == 4'd0) begin
          tx_tcnt  <= 4'd15;
          tx_bcnt  <= tx_bcnt + 4'd1;
          tx_shift <= {1'b1, tx_shift[9:1]};
        end else begin
          tx_tcnt <= tx_tcnt - 4'd1;
        end
      end
    end
  end

  assign uart_txd = (tx_state == TX_SEND) ? tx_shift[0] : 1'b1;
  assign tx_busy  = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at 50 MHz / 900 kbaud (D = 3, 48 clk per bit).
module tb_uart_core;
  localparam int FREQ = 50000000;
  localparam int BAUD = 900000;
  localparam int BIT  = 48;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_ack = 1'b0;
  logic       tx_wr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       uart_rxd, uart_txd, rx_avail, rx_error, tx_busy;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  uart_core #(.freq_hz(FREQ), .baud(BAUD)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic wait_avail(input string tag);
    int n = 0;
    while (!rx_avail && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, rx_avail, 1);
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_busy, 0);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    rxd_drv = stop_bit;
    // a bad stop bit is kept short so its tail cannot pass as a new start bit
    repeat (stop_bit ? BIT : 32) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp_bits;
    int a, b, n;
    logic low_seen;

    repeat (5) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_avail", rx_avail, 0);
    check("rst_rx_error", rx_error, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // transmit 0x67, with an ignored 0x55 write in the middle
    exp_bits = {1'b1, 8'h67, 1'b0};
    write_tx(8'h67);
    a = cyc;
    check("tx_busy_accept", tx_busy, 1);
    n = 0;
    while (uart_txd && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", uart_txd, 0);
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), uart_txd, exp_bits[i]);
      if (i < 9) begin
        if (i == 3) begin
          tx_data = 8'h55;
          tx_wr = 1'b1;
          @(negedge clk);
          tx_wr = 1'b0;
          repeat (BIT - 1) @(negedge clk);
        end else begin
          repeat (BIT) @(negedge clk);
        end
      end
    end
    wait_tx_idle("tx_busy_fall");
    b = cyc;
    check("tx_busy_len", (b - a >= 477 && b - a <= 483), 1);
    low_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (!uart_txd) low_seen = 1'b1;
    end
    check("tx_wr_ignored", low_seen, 0);

    // loopback 0x67 then 0x00
    loop_en = 1'b1;
    write_tx(8'h67);
    wait_avail("lb_avail_67");
    check("lb_data_67", rx_data, 8'h67);
    check("lb_err_67", rx_error, 0);
    pulse_ack();
    @(negedge clk);
    check("lb_ack_clears", rx_avail, 0);
    wait_tx_idle("lb_tx_idle_1");
    write_tx(8'h00);
    wait_avail("lb_avail_00");
    check("lb_data_00", rx_data, 8'h00);
    check("lb_err_00", rx_error, 0);
    pulse_ack();
    wait_tx_idle("lb_tx_idle_2");
    repeat (BIT) @(negedge clk);
    loop_en = 1'b0;

    // framing error
    drive_frame(8'h3C, 1'b0);
    check("fe_error", rx_error, 1);
    check("fe_avail", rx_avail, 0);
    check("fe_data_kept", rx_data, 8'h00);
    pulse_ack();
    @(negedge clk);
    check("fe_ack_clears", rx_error, 0);

    // 16-clk glitch, then a valid 0xA5
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("gl_avail", rx_avail, 0);
    check("gl_error", rx_error, 0);
    drive_frame(8'hA5, 1'b1);
    check("a5_avail", rx_avail, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_error", rx_error, 0);

    // reset mid-frame
    write_tx(8'h67);
    repeat (100) @(negedge clk);
    check("mid_busy", tx_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_avail", rx_avail, 0);
    check("mid_rst_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
